// File: rtl/day_3_kdigit_joltage_if.sv
// Stream bundle for the k-digit joltage solver: digit input stream plus puzzle-sum output stream.
// slave is the solver's view; master is the driver/monitor view.
interface day_3_kdigit_joltage_if #(
  parameter int unsigned INPUTWIDTH  = 8,
  parameter int unsigned OUTPUTWIDTH = 64
);
  logic [INPUTWIDTH-1:0]  s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic                   s_axis_tuser;
  logic [OUTPUTWIDTH-1:0] m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser
  );
endinterface

// File: rtl/day_3_kdigit_joltage.sv
// Streaming solver: per bank, largest K_DIGITS-digit ordered subsequence (BCD DP), Horner-converted and summed.
// Optional macro DAY3_SATURATE_EN: puzzle sum saturates at all-ones and flags the error bit instead of wrapping.
module day_3_kdigit_joltage #(
  parameter int unsigned INPUTWIDTH  = 8,
  parameter int unsigned OUTPUTWIDTH = 64,
  parameter int unsigned K_DIGITS    = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  day_3_kdigit_joltage_if.slave        axis
);

  // Bits needed to hold 10^k - 1.
  function automatic int unsigned min_out_w(input int unsigned k);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < k; i++) p = p * 64'd10;
    return $clog2(p);
  endfunction

  localparam int unsigned BCD_W     = K_DIGITS * 4;
  localparam int unsigned CNT_W     = $clog2(K_DIGITS + 1);
  localparam int unsigned STEP_W    = (K_DIGITS > 1) ? $clog2(K_DIGITS) : 1;
  localparam int unsigned MIN_OUT_W = min_out_w(K_DIGITS);

  if (K_DIGITS == 0 || K_DIGITS > 16) begin : g_bad_k
    $error("K_DIGITS must be in 1..16");
  end
  if (OUTPUTWIDTH < MIN_OUT_W) begin : g_bad_out
    $error("OUTPUTWIDTH too narrow for K_DIGITS decimal digits");
  end
  if (INPUTWIDTH < 4) begin : g_bad_in
    $error("INPUTWIDTH must be at least 4");
  end
  if (INPUTWIDTH > 4) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^axis.s_axis_tdata[INPUTWIDTH-1:4];
  end

  typedef enum logic [1:0] {
    S_ACCEPT  = 2'd0,
    S_CONVERT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BCD_W-1:0]       best_q [K_DIGITS];
  logic [BCD_W-1:0]       best_d [K_DIGITS];
  logic [BCD_W-1:0]       best_upd [K_DIGITS];
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_upd;
  logic [CNT_W:0]         cnt_p1;
  logic [BCD_W-1:0]       conv_q, conv_d;
  logic [OUTPUTWIDTH-1:0] acc_q, acc_d, acc_n;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   end_q, end_d;
  logic [OUTPUTWIDTH-1:0] sum_q, sum_d;
  logic                   err_q, err_d;
  logic [3:0]             digit, conv_digit;
  logic                   is_digit;

  assign digit      = axis.s_axis_tdata[3:0];
  assign is_digit   = (digit <= 4'd9);
  assign cnt_p1     = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
  assign cnt_upd    = !is_digit ? cnt_q :
                      (cnt_p1 > (CNT_W+1)'(K_DIGITS)) ? CNT_W'(K_DIGITS) : cnt_p1[CNT_W-1:0];
  assign conv_digit = conv_q[BCD_W-1 -: 4];
  assign acc_n      = acc_q * OUTPUTWIDTH'(10) + OUTPUTWIDTH'(conv_digit);

  // best[j] = max(best[j], best[j-1]*10 + d); index g holds best[g+1], only reachable lengths update.
  for (genvar g = 0; g < K_DIGITS; g++) begin : g_dp
    logic [BCD_W-1:0] prev;
    logic [BCD_W-1:0] cand;
    if (g == 0) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = best_q[g-1];
    end
    assign cand        = (prev << 4) | BCD_W'(digit);
    assign best_upd[g] = (is_digit && (cnt_p1 > (CNT_W+1)'(g)) && (cand > best_q[g])) ? cand
                                                                                   : best_q[g];
  end

`ifdef DAY3_SATURATE_EN
  logic [OUTPUTWIDTH:0] sum_wide;
  assign sum_wide = {1'b0, sum_q} + {1'b0, acc_n};
`endif

  // Next-state and datapath update.
  always_comb begin : fsm_next
    state_d = state_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    acc_d   = acc_q;
    step_d  = step_q;
    end_d   = end_q;
    sum_d   = sum_q;
    err_d   = err_q;

    case (state_q)
      S_ACCEPT: begin
        if (axis.s_axis_tvalid) begin
          if (!is_digit) err_d = 1'b1;
          if (axis.s_axis_tlast) begin
            // A short bank leaves best[K] at zero, so it contributes nothing.
            conv_d  = best_upd[K_DIGITS-1];
            end_d   = axis.s_axis_tuser;
            acc_d   = '0;
            step_d  = '0;
            best_d  = '{default: '0};
            cnt_d   = '0;
            if (cnt_upd != CNT_W'(K_DIGITS)) err_d = 1'b1;
            state_d = S_CONVERT;
          end else begin
            best_d = best_upd;
            cnt_d  = cnt_upd;
          end
        end
      end

      S_CONVERT: begin
        acc_d  = acc_n;
        conv_d = conv_q << 4;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(K_DIGITS - 1)) begin
`ifdef DAY3_SATURATE_EN
          if (sum_wide[OUTPUTWIDTH]) begin
            sum_d = '1;
            err_d = 1'b1;
          end else begin
            sum_d = sum_wide[OUTPUTWIDTH-1:0];
          end
`else
          sum_d = sum_q + acc_n;
`endif
          state_d = end_q ? S_OUTPUT : S_ACCEPT;
        end
      end

      S_OUTPUT: begin
        if (axis.m_axis_tready) begin
          sum_d   = '0;
          err_d   = 1'b0;
          state_d = S_ACCEPT;
        end
      end

      default: state_d = S_ACCEPT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q <= S_ACCEPT;
      best_q  <= '{default: '0};
      cnt_q   <= '0;
      conv_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      end_q   <= 1'b0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      conv_q  <= conv_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      end_q   <= end_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  assign axis.s_axis_tready = (state_q == S_ACCEPT);
  assign axis.m_axis_tvalid = (state_q == S_OUTPUT);
  assign axis.m_axis_tdata  = sum_q;
  assign axis.m_axis_tuser  = err_q;

endmodule

// File: tb/tb_day_3_kdigit_joltage.sv
// Bench for day_3_kdigit_joltage: K=2 and K=12 instances fed the same digit stream,
// greedy reference model feeding per-instance expected-result queues.
module tb_day_3_kdigit_joltage;

  localparam int unsigned OW = 64;

  typedef struct {
    logic [OW-1:0] sum;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  day_3_kdigit_joltage_if #(.INPUTWIDTH(8), .OUTPUTWIDTH(OW)) bus2 ();
  day_3_kdigit_joltage_if #(.INPUTWIDTH(8), .OUTPUTWIDTH(OW)) bus12 ();

  day_3_kdigit_joltage #(.INPUTWIDTH(8), .OUTPUTWIDTH(OW), .K_DIGITS(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .axis(bus2.slave)
  );
  day_3_kdigit_joltage #(.INPUTWIDTH(8), .OUTPUTWIDTH(OW), .K_DIGITS(12)) u_k12 (
    .clk(clk), .rst_n(rst_n), .axis(bus12.slave)
  );

  int errors = 0;
  int checks = 0;

  exp_t q2[$];
  exp_t q12[$];
  logic [OW-1:0] msum [2];
  bit            merr [2];
  int            lat_cnt [2];
  bit            armed [2];

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Greedy reference: pick the leftmost maximum within each feasible window.
  function automatic logic [OW-1:0] best_of(input int unsigned k, input int digs[$]);
    logic [OW-1:0] v;
    int start;
    v = '0;
    start = 0;
    for (int p = 0; p < int'(k); p++) begin
      int hi;
      int bi;
      hi = digs.size() - int'(k) + p;
      bi = start;
      for (int i = start; i <= hi; i++) if (digs[i] > digs[bi]) bi = i;
      v = v * OW'(10) + OW'(digs[bi]);
      start = bi + 1;
    end
    return v;
  endfunction

  task automatic model_bank(input string s, input bit fin);
    int digs[$];
    bit bad;
    int unsigned ks [2];
    bad = 1'b0;
    ks[0] = 2;
    ks[1] = 12;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] >= "0" && s[i] <= "9") digs.push_back(int'(s[i]) - int'("0"));
      else bad = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      if (bad) merr[m] = 1'b1;
      if (digs.size() < int'(ks[m])) merr[m] = 1'b1;
      else msum[m] = msum[m] + best_of(ks[m], digs);
      if (fin) begin
        exp_t e;
        e.sum = msum[m];
        e.err = merr[m];
        if (m == 0) q2.push_back(e);
        else q12.push_back(e);
        msum[m] = '0;
        merr[m] = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] enc(input byte c, input bit ascii);
    if (c == "x") return ascii ? 8'h3A : 8'h0F;
    return ascii ? 8'(c) : 8'(c - "0");
  endfunction

  // Offer one beat to both instances; each drops valid once it has taken it.
  task automatic send_beat(input logic [7:0] data, input bit last, input bit user, input bit gaps);
    bit p2, p12, f2, f12;
    int guard;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus2.s_axis_tdata = data;   bus12.s_axis_tdata = data;
    bus2.s_axis_tlast = last;   bus12.s_axis_tlast = last;
    bus2.s_axis_tuser = user;   bus12.s_axis_tuser = user;
    bus2.s_axis_tvalid = 1'b1;  bus12.s_axis_tvalid = 1'b1;
    p2 = 1'b1;
    p12 = 1'b1;
    guard = 0;
    while (p2 || p12) begin
      @(negedge clk);
      f2  = p2 && bus2.s_axis_tready;
      f12 = p12 && bus12.s_axis_tready;
      @(posedge clk);
      #1;
      if (f2)  begin p2 = 1'b0;  bus2.s_axis_tvalid = 1'b0;  end
      if (f12) begin p12 = 1'b0; bus12.s_axis_tvalid = 1'b0; end
      guard++;
      if (guard > 500) begin
        check("beat_accept_timeout", OW'(guard), OW'(0));
        bus2.s_axis_tvalid = 1'b0;
        bus12.s_axis_tvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_bank(input string s, input bit fin, input bit ascii, input bit gaps);
    model_bank(s, fin);
    for (int i = 0; i < s.len(); i++) begin
      bit last;
      last = (i == s.len() - 1);
      send_beat(enc(s[i], ascii), last, last ? fin : 1'($urandom_range(0, 1)), gaps);
    end
  endtask

  task automatic send_puzzle(input bit ascii, input bit gaps);
    send_bank("987654321111111", 1'b0, ascii, gaps);
    send_bank("811111111111119", 1'b0, ascii, gaps);
    send_bank("234234234234278", 1'b0, ascii, gaps);
    send_bank("818181911112111", 1'b1, ascii, gaps);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus2.s_axis_tvalid = 1'b0;
    bus12.s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      msum[m] = '0;
      merr[m] = 1'b0;
    end
    q2.delete();
    q12.delete();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q2.size() != 0 || q12.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", OW'(q2.size() + q12.size()), OW'(0));
    @(posedge clk);
    #1;
  endtask

  // Per-instance output scoreboard, stall checks and post-tlast busy-cycle count.
  task automatic monitor(input int idx, input int unsigned k, input logic sv, input logic sr,
                         input logic sl, input logic mv, input logic mr,
                         input logic [OW-1:0] md, input logic mu);
    exp_t e;
    bit have;
    if (!rst_n) begin
      armed[idx] = 1'b0;
      return;
    end
    if (armed[idx]) begin
      if (sr || mv) begin
        check($sformatf("k%0d_busy_cycles", k), OW'(lat_cnt[idx]), OW'(k));
        armed[idx] = 1'b0;
      end else begin
        lat_cnt[idx]++;
      end
    end
    if (sv && sr && sl) begin
      armed[idx] = 1'b1;
      lat_cnt[idx] = 0;
    end
    if (mv) begin
      have = (idx == 0) ? (q2.size() != 0) : (q12.size() != 0);
      if (!have) begin
        check($sformatf("k%0d_unexpected_valid", k), OW'(mv), OW'(0));
      end else begin
        e = (idx == 0) ? q2[0] : q12[0];
        check($sformatf("k%0d_sum", k), md, e.sum);
        check($sformatf("k%0d_err", k), OW'(mu), OW'(e.err));
        if (!mr) check($sformatf("k%0d_stall_s_ready", k), OW'(sr), OW'(0));
        else if (idx == 0) void'(q2.pop_front());
        else void'(q12.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, 2, bus2.s_axis_tvalid, bus2.s_axis_tready, bus2.s_axis_tlast,
            bus2.m_axis_tvalid, bus2.m_axis_tready, bus2.m_axis_tdata, bus2.m_axis_tuser);
    monitor(1, 12, bus12.s_axis_tvalid, bus12.s_axis_tready, bus12.s_axis_tlast,
            bus12.m_axis_tvalid, bus12.m_axis_tready, bus12.m_axis_tdata, bus12.m_axis_tuser);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int m = 0; m < 2; m++) begin
      msum[m] = '0;
      merr[m] = 1'b0;
      armed[m] = 1'b0;
      lat_cnt[m] = 0;
    end
    bus2.s_axis_tdata = '0;   bus12.s_axis_tdata = '0;
    bus2.s_axis_tvalid = 1'b0; bus12.s_axis_tvalid = 1'b0;
    bus2.s_axis_tlast = 1'b0; bus12.s_axis_tlast = 1'b0;
    bus2.s_axis_tuser = 1'b0; bus12.s_axis_tuser = 1'b0;
    bus2.m_axis_tready = 1'b1; bus12.m_axis_tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", OW'(bus12.m_axis_tvalid), OW'(0));
    check("rst_m_data", bus12.m_axis_tdata, OW'(0));
    check("rst_m_user", OW'(bus12.m_axis_tuser), OW'(0));
    check("rst_s_ready", OW'(bus12.s_axis_tready), OW'(1));
    check("rst_k2_m_valid", OW'(bus2.m_axis_tvalid), OW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single bank, then the four-bank puzzle raw, then ASCII with valid gaps.
    send_bank("987654321111111", 1'b1, 1'b0, 1'b0);
    send_puzzle(1'b0, 1'b0);
    send_puzzle(1'b1, 1'b1);
    drain();

    // Output stall: hold m_axis_tready low for 5 cycles after both results are up.
    bus2.m_axis_tready = 1'b0;
    bus12.m_axis_tready = 1'b0;
    send_puzzle(1'b0, 1'b0);
    guard = 0;
    while (!(bus2.m_axis_tvalid && bus12.m_axis_tvalid) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("stall_valid_seen", OW'(bus12.m_axis_tvalid), OW'(1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    bus2.m_axis_tready = 1'b1;
    bus12.m_axis_tready = 1'b1;

    // Fresh puzzle after handshake: short bank, then a non-digit mid-bank.
    send_bank("12345", 1'b0, 1'b0, 1'b0);
    send_bank("987654321111111", 1'b1, 1'b0, 1'b0);
    send_bank("9876x54321111111", 1'b1, 1'b1, 1'b1);
    send_bank("5", 1'b1, 1'b0, 1'b0);
    drain();

    // Reset mid-bank, then reset during conversion: neither may produce output.
    for (int i = 0; i < 6; i++) send_beat(8'd8, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_bank("123456789012345", 1'b1, 1'b0, 1'b0);
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    send_bank("811111111111119", 1'b1, 1'b0, 1'b0);
    drain();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/day_3_kdigit_joltage.md
Name: day_3_kdigit_joltage

Overview:
- Streaming successor to the two-digit bank solver, generalised to choose K_DIGITS digits per bank.
- Accepts one decimal digit per AXI4-Stream beat, with tlast ending a bank. For each bank it finds the largest K_DIGITS-digit number formed by an order-preserving subsequence of the bank's digits.
- Converts that number to binary and accumulates it. The puzzle total is emitted on the master stream when the puzzle-end beat arrives.
- K_DIGITS=2 reproduces part 1; K_DIGITS=12 solves part 2.

Parameters:
- INPUTWIDTH, 8, s_axis_tdata width. Only tdata[3:0] is used, so raw binary digits 0-9 and ASCII '0'-'9' are both accepted.
- OUTPUTWIDTH, 64, width of the sum and m_axis_tdata. Elaboration error if OUTPUTWIDTH < ceil(K_DIGITS*log2(10)).
- K_DIGITS, 12, digits selected per bank. Legal range 1..16.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  INPUTWIDTH  digit in bits [3:0]
- s_axis_tvalid  in  1  slave valid
- s_axis_tready  out  1  slave ready
- s_axis_tlast  in  1  last digit of the current bank
- s_axis_tuser  in  1  sampled only on a tlast beat; 1 = last bank of the puzzle
- m_axis_tdata  out  OUTPUTWIDTH  puzzle sum
- m_axis_tvalid  out  1  master valid
- m_axis_tready  in  1  master ready
- m_axis_tuser  out  1  sticky error: short bank or non-digit seen during this puzzle

Behaviour:
- Reset: state S_ACCEPT, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, sum=0, all best[] and cnt cleared. Reset mid-bank or mid-output discards everything; no partial result is ever emitted.
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- s_axis_tready = (state == S_ACCEPT), purely combinational from state.
- DP registers:
  - best[1..K_DIGITS], each a K_DIGITS*4-bit BCD vector, right-aligned.
  - cnt, the bank length, saturating at K_DIGITS.
- On an accepted beat with digit d (tdata[3:0] <= 9), update all j in parallel using pre-update values:
  - best[j] <= max(best[j], best[j-1]*10 + d), where best[0]=0.
  - The BCD shift-append is a 4-bit left shift OR d. The max is an unsigned compare of packed BCD.
  - j is only updated when j <= cnt+1. Then cnt <= min(cnt+1, K_DIGITS).
- Non-digit beat (tdata[3:0] > 9): sets the error bit and leaves best[] and cnt unchanged. It is still consumed, and its tlast/tuser still act.
- States:
  - S_ACCEPT: consumes beats. A tlast handshake latches best[K_DIGITS] into a conversion register, latches puzzle_end = tuser, clears best[] and cnt, and goes to S_CONVERT.
  - S_CONVERT: exactly K_DIGITS cycles of Horner conversion, acc = acc*10 + next BCD digit, MSD first. On the final cycle, sum <= sum + acc, wrapping modulo 2^OUTPUTWIDTH. Next state is S_OUTPUT if puzzle_end, else S_ACCEPT.
  - If cnt < K_DIGITS at tlast (short bank, including an empty or all-invalid bank), the bank contributes 0 and the error bit is set.
  - S_OUTPUT: m_axis_tvalid=1, m_axis_tdata=sum, m_axis_tuser=error, all held stable until m_axis_tready. On the handshake cycle, sum and error are cleared and the state becomes S_ACCEPT. m_axis_tvalid is 0 the next cycle.
- Latency:
  - tlast handshake at cycle t puts s_axis_tready high again at t+K_DIGITS+1 (non-final bank).
  - For a final bank, m_axis_tvalid rises at t+K_DIGITS+1.
  - Throughput is 1 digit/cycle within a bank.
- Single-digit bank with K_DIGITS=1 is legal. tlast and tuser on the same beat as the only digit work normally.

Optional Feature:
- Macro DAY3_SATURATE_EN.
- Defined: the sum saturates at all-ones instead of wrapping, and saturation also sets the m_axis_tuser error bit.
- Undefined: modulo-2^OUTPUTWIDTH wrap, and the error bit reflects only short/non-digit banks.

Test Plan:
- K_DIGITS=2, single bank "987654321111111" with tuser=1 on tlast -> m_axis_tdata=98, m_axis_tuser=0.
- K_DIGITS=2, banks 987654321111111 / 811111111111119 / 234234234234278 / 818181911112111, tuser on the last -> 357. Same stream with K_DIGITS=12 -> 3121910778619.
- Same stream sent as ASCII, with random s_axis_tvalid gaps -> identical sums. s_axis_tready is low for exactly K_DIGITS cycles after each tlast.
- m_axis_tready held low 5 cycles in S_OUTPUT -> tvalid and tdata stable and s_axis_tready=0. Handshake -> sum restarts at 0 for the next puzzle.
- K_DIGITS=12:
  - bank "12345" then "987654321111111" (final) -> 987654321111, m_axis_tuser=1.
  - a 'x' mid-bank -> ignored digit, tuser=1.
- rst_n pulsed low mid-bank and again during S_CONVERT -> no output. The subsequent bank "811111111111119" with K_DIGITS=12 -> 811111111119, tuser=0.
